// File: rtl/debug_bridge_pkg.sv
// debug_bridge_pkg
//   Shared definitions for the debug bridge: host command codes, memory
//   read/write encoding and the FSM state codes.
package debug_bridge_pkg;

    // Host command codes (first byte of every command)
    localparam logic [7:0] CMD_NOP   = 8'd0;
    localparam logic [7:0] CMD_ECHO  = 8'd1;
    localparam logic [7:0] CMD_WRITE = 8'd2;
    localparam logic [7:0] CMD_READ  = 8'd3;
    localparam logic [7:0] CMD_FILL  = 8'd4;
    localparam logic [7:0] CMD_ID    = 8'd5;

    // o_mem_rw encoding
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // FSM state codes
    typedef logic [3:0] state_t;
    localparam state_t ST_IDLE     = 4'd0;
    localparam state_t ST_HDR      = 4'd1;
    localparam state_t ST_ECHO_RX  = 4'd2;
    localparam state_t ST_WR_RX    = 4'd3;
    localparam state_t ST_WR_MEM   = 4'd4;
    localparam state_t ST_RD_MEM   = 4'd5;
    localparam state_t ST_TX       = 4'd6;
    localparam state_t ST_FILL_RX  = 4'd7;
    localparam state_t ST_FILL_MEM = 4'd8;

    // States in which an incoming RX byte is consumed; anywhere else it is
    // dropped and flagged as an overrun.
    function automatic logic is_rx_state(input state_t s);
        return (s == ST_IDLE) || (s == ST_HDR) || (s == ST_ECHO_RX) ||
               (s == ST_WR_RX) || (s == ST_FILL_RX);
    endfunction

endpackage

// File: rtl/debug_bridge_hdr_shift.sv
// debug_bridge_hdr_shift
//   Collects the ADDR_BYTES+LEN_BYTES header bytes (MSB first) of a
//   WRITE/READ/FILL command. o_addr/o_len are presented combinationally
//   including the byte currently on i_byte, so the parent can latch them in
//   the same cycle that o_done strobes.
// Ports:
//   i_clk, i_reset_n  clock, asynchronous active-low reset
//   i_dv, i_byte      header byte strobe and value
//   o_addr, o_len     assembled address / length fields
//   o_done            high with the final header byte
module debug_bridge_hdr_shift #(
    parameter int ADDR_BYTES = 2,
    parameter int LEN_BYTES  = 2
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_dv,
    input  logic [7:0]              i_byte,
    output logic [8*ADDR_BYTES-1:0] o_addr,
    output logic [8*LEN_BYTES-1:0]  o_len,
    output logic                    o_done
);
    localparam int TOT = ADDR_BYTES + LEN_BYTES;
    localparam int CW  = $clog2(TOT + 1);

    logic [8*TOT-1:0] shift_reg;
    logic [8*TOT-1:0] shift_next;
    logic [CW-1:0]    count_reg;

    // Byte lane gi takes the lane below it; lane 0 takes the new byte.
    genvar gi;
    generate
        for (gi = 0; gi < TOT; gi++) begin : g_lane
            if (gi == 0) begin : g_first
                assign shift_next[7:0] = i_byte;
            end else begin : g_rest
                assign shift_next[8*gi +: 8] = shift_reg[8*(gi-1) +: 8];
            end
        end
    endgenerate

    assign o_done = i_dv && (count_reg == CW'(TOT - 1));
    assign o_len  = shift_next[8*LEN_BYTES-1:0];
    assign o_addr = shift_next[8*TOT-1 -: 8*ADDR_BYTES];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            shift_reg <= '0;
            count_reg <= '0;
        end else if (i_dv) begin
            shift_reg <= shift_next;
            count_reg <= o_done ? '0 : count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/debug_bridge.sv
// debug_bridge
//   Byte-stream debug command processor between a UART RX/TX pair and a
//   memory port. Commands: NOP, ECHO, WRITE, READ, FILL, ID (unknown = NOP).
//   Optional macro DEBUG_BRIDGE_CHECKSUM_EN: READ appends an XOR checksum
//   byte of the data bytes it sent (8'h00 for a zero-length READ).
// Ports:
//   i_clk, i_reset_n            clock, asynchronous active-low reset
//   i_rx_dv, i_rx_byte          received byte strobe / value
//   o_tx_dv, o_tx_byte          TX byte, held until i_tx_ready
//   i_tx_ready                  TX accept
//   o_mem_en, o_mem_rw          memory request (held until ack), 1=read
//   o_mem_address, o_mem_data   request address / write data
//   i_mem_data, i_mem_ack       read data / completion strobe
//   o_busy, o_overrun, o_cmd    status: not idle, dropped RX byte, command
module debug_bridge
    import debug_bridge_pkg::*;
#(
    parameter int         ADDR_BYTES = 2,
    parameter int         LEN_BYTES  = 2,
    parameter logic [7:0] ID_VALUE   = 8'hA5
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_rx_dv,
    input  logic [7:0]              i_rx_byte,
    output logic                    o_tx_dv,
    output logic [7:0]              o_tx_byte,
    input  logic                    i_tx_ready,
    output logic                    o_mem_en,
    output logic                    o_mem_rw,
    output logic [8*ADDR_BYTES-1:0] o_mem_address,
    output logic [7:0]              o_mem_data,
    input  logic [7:0]              i_mem_data,
    input  logic                    i_mem_ack,
    output logic                    o_busy,
    output logic                    o_overrun,
    output logic [7:0]              o_cmd
);
    localparam int AW = 8 * ADDR_BYTES;
    localparam int LW = 8 * LEN_BYTES;

    state_t        state_reg, state_next;
    logic [7:0]    cmd_reg, cmd_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic [LW-1:0] len_reg, len_next;
    logic [7:0]    tx_byte_reg, tx_byte_next;
    logic [7:0]    wdata_reg, wdata_next;
    logic          overrun_reg, overrun_next;
`ifdef DEBUG_BRIDGE_CHECKSUM_EN
    logic [7:0]    chk_reg, chk_next;
    logic          chk_done_reg, chk_done_next;
`endif

    logic [AW-1:0] hdr_addr;
    logic [LW-1:0] hdr_len;
    logic          hdr_done;
    logic          mem_write;

    debug_bridge_hdr_shift #(
        .ADDR_BYTES (ADDR_BYTES),
        .LEN_BYTES  (LEN_BYTES)
    ) u_hdr_shift (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_dv      (i_rx_dv && (state_reg == ST_HDR)),
        .i_byte    (i_rx_byte),
        .o_addr    (hdr_addr),
        .o_len     (hdr_len),
        .o_done    (hdr_done)
    );

    always_comb begin
        state_next    = state_reg;
        cmd_next      = cmd_reg;
        addr_next     = addr_reg;
        len_next      = len_reg;
        tx_byte_next  = tx_byte_reg;
        wdata_next    = wdata_reg;
        overrun_next  = i_rx_dv && !is_rx_state(state_reg);
`ifdef DEBUG_BRIDGE_CHECKSUM_EN
        chk_next      = chk_reg;
        chk_done_next = chk_done_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (i_rx_dv) begin
                    cmd_next = i_rx_byte;
                    case (i_rx_byte)
                        CMD_WRITE, CMD_FILL: state_next = ST_HDR;
                        CMD_READ: begin
                            state_next = ST_HDR;
`ifdef DEBUG_BRIDGE_CHECKSUM_EN
                            chk_next      = 8'h00;
                            chk_done_next = 1'b0;
`endif
                        end
                        CMD_ECHO: state_next = ST_ECHO_RX;
                        CMD_ID: begin
                            tx_byte_next = ID_VALUE;
                            state_next   = ST_TX;
                        end
                        default: cmd_next = CMD_NOP;
                    endcase
                end
            end
            ST_HDR: begin
                if (hdr_done) begin
                    addr_next = hdr_addr;
                    len_next  = hdr_len;
                    if (hdr_len == '0) begin
                        state_next = ST_IDLE;
`ifdef DEBUG_BRIDGE_CHECKSUM_EN
                        // Empty READ still reports its (zero) checksum
                        if (cmd_reg == CMD_READ) begin
                            tx_byte_next  = 8'h00;
                            chk_done_next = 1'b1;
                            state_next    = ST_TX;
                        end
`endif
                    end else begin
                        case (cmd_reg)
                            CMD_WRITE: state_next = ST_WR_RX;
                            CMD_READ:  state_next = ST_RD_MEM;
                            default:   state_next = ST_FILL_RX;
                        endcase
                    end
                end
            end
            ST_ECHO_RX: begin
                if (i_rx_dv) begin
                    tx_byte_next = i_rx_byte;
                    state_next   = ST_TX;
                end
            end
            ST_WR_RX, ST_FILL_RX: begin
                if (i_rx_dv) begin
                    wdata_next = i_rx_byte;
                    state_next = (state_reg == ST_WR_RX) ? ST_WR_MEM : ST_FILL_MEM;
                end
            end
            ST_WR_MEM, ST_FILL_MEM: begin
                if (i_mem_ack) begin
                    addr_next = addr_reg + 1'b1;
                    len_next  = len_reg - 1'b1;
                    if (len_reg == LW'(1))
                        state_next = ST_IDLE;
                    else if (state_reg == ST_WR_MEM)
                        state_next = ST_WR_RX;
                end
            end
            ST_RD_MEM: begin
                if (i_mem_ack) begin
                    tx_byte_next = i_mem_data;
                    addr_next    = addr_reg + 1'b1;
                    len_next     = len_reg - 1'b1;
                    state_next   = ST_TX;
                end
            end
            ST_TX: begin
                if (i_tx_ready) begin
                    if (cmd_reg == CMD_READ && len_reg != '0) begin
                        state_next = ST_RD_MEM;
`ifdef DEBUG_BRIDGE_CHECKSUM_EN
                        chk_next   = chk_reg ^ tx_byte_reg;
`endif
                    end else begin
                        state_next = ST_IDLE;
`ifdef DEBUG_BRIDGE_CHECKSUM_EN
                        // Last data byte accepted: follow it with the checksum
                        if (cmd_reg == CMD_READ && !chk_done_reg) begin
                            tx_byte_next  = chk_reg ^ tx_byte_reg;
                            chk_done_next = 1'b1;
                            state_next    = ST_TX;
                        end
`endif
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg    <= ST_IDLE;
            cmd_reg      <= '0;
            addr_reg     <= '0;
            len_reg      <= '0;
            tx_byte_reg  <= '0;
            wdata_reg    <= '0;
            overrun_reg  <= 1'b0;
`ifdef DEBUG_BRIDGE_CHECKSUM_EN
            chk_reg      <= '0;
            chk_done_reg <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            cmd_reg      <= cmd_next;
            addr_reg     <= addr_next;
            len_reg      <= len_next;
            tx_byte_reg  <= tx_byte_next;
            wdata_reg    <= wdata_next;
            overrun_reg  <= overrun_next;
`ifdef DEBUG_BRIDGE_CHECKSUM_EN
            chk_reg      <= chk_next;
            chk_done_reg <= chk_done_next;
`endif
        end
    end

    assign mem_write     = (state_reg == ST_WR_MEM) || (state_reg == ST_FILL_MEM);
    assign o_mem_en      = mem_write || (state_reg == ST_RD_MEM);
    assign o_mem_rw      = mem_write ? RW_WRITE : RW_READ;
    assign o_mem_address = o_mem_en ? addr_reg : '0;
    assign o_mem_data    = mem_write ? wdata_reg : 8'h00;
    assign o_tx_dv       = (state_reg == ST_TX);
    assign o_tx_byte     = o_tx_dv ? tx_byte_reg : 8'h00;
    assign o_busy        = (state_reg != ST_IDLE);
    assign o_overrun     = overrun_reg;
    assign o_cmd         = o_busy ? cmd_reg : 8'h00;

endmodule
